// File: rtl/hn_pkg.sv
// Shared definitions for the print-head line reader: FSM states, default geometry and head count.
package hn_pkg;

   localparam int HEAD_N       = 4;
   localparam int DEF_ADDR_W   = 10;
   localparam int DEF_LINE_LEN = 100;
   localparam int DEF_RD_LAT   = 2;
   localparam int DEF_CLK_DIV  = 2;
   localparam int DEF_LATCH_W  = 4;
   localparam int TIMER_W      = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_SCLK_LO,
      ST_SCLK_HI,
      ST_LATCH,
      ST_DONE
   } state_t;

endpackage

// File: rtl/hn_line_reader_if.sv
// Read port between the line reader and the line-buffer bank.
interface hn_line_reader_if
   import hn_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
);

   logic              rden;
   logic [ADDR_W-1:0] rdaddress;
   logic [HEAD_N-1:0] PrnData;

   modport master (output rden, output rdaddress, input PrnData);
   modport slave  (input rden, input rdaddress, output PrnData);

endinterface

// File: rtl/hn_sclk_timer.sv
// Down-counter that measures how long the reader stays in a timed state.
module hn_sclk_timer
   import hn_pkg::*;
#(
   parameter int W = TIMER_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_loadVal,
   output logic         o_expire
);

   logic [W-1:0] r_count;

   // Loading N makes expire rise on the N-th cycle of the state just entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_loadVal - 1'b1;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_expire = (r_count == '0);

endmodule

// File: rtl/hn_line_reader.sv
// Sweeps one line of the head buffers and shifts each 4-bit column word out to the heads,
// finishing with a latch strobe and a done pulse.
module hn_line_reader
   import hn_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int LINE_LEN = DEF_LINE_LEN,
   parameter int RD_LAT   = DEF_RD_LAT,
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int LATCH_W  = DEF_LATCH_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  rev,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic                  abort,
   hn_line_reader_if.master      bufBus,
   output logic [HEAD_N-1:0]     head_sdat,
   output logic                  head_sclk,
   output logic                  head_latch,
   output logic                  busy,
   output logic                  done,
   output logic                  overrun
);

   localparam logic [ADDR_W-1:0]  LAST_IDX = ADDR_W'(LINE_LEN - 1);
   localparam logic [TIMER_W-1:0] T_RD     = TIMER_W'(RD_LAT);
   localparam logic [TIMER_W-1:0] T_DIV    = TIMER_W'(CLK_DIV);
   localparam logic [TIMER_W-1:0] T_LAT    = TIMER_W'(LATCH_W);

   state_t              r_state;
   state_t              w_nextState;
   logic [ADDR_W-1:0]   r_idx;
   logic [ADDR_W-1:0]   r_rdAddress;
   logic                r_rev;
   logic [HEAD_N-1:0]   r_headSdat;
   logic                r_overrun;
   logic                w_expire;
   logic                w_timerLoad;
   logic [TIMER_W-1:0]  w_timerVal;
   logic                w_busy;
   logic                w_accept;
   logic                w_abort;
   logic                w_lastCol;
   logic                w_advance;

   assign w_busy    = (r_state != ST_IDLE) && (r_state != ST_DONE);
   assign w_accept  = start && !w_busy;
   assign w_abort   = abort && w_busy;
   assign w_lastCol = (r_idx == LAST_IDX);
   assign w_advance = (r_state == ST_SCLK_HI) && w_expire && !w_lastCol;

   hn_sclk_timer #(.W(TIMER_W)) u_timer (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_timerLoad),
      .i_loadVal (w_timerVal),
      .o_expire  (w_expire)
   );

   // The DONE cycle doubles as an idle slot, so a new start is taken there too.
   always_comb begin
      w_nextState = r_state;
      w_timerVal  = TIMER_W'(1);
      case (r_state)
         ST_IDLE:    if (start) w_nextState = ST_FETCH;
         ST_FETCH:   w_nextState = ST_WAIT;
         ST_WAIT:    if (w_expire) w_nextState = ST_SCLK_LO;
         ST_SCLK_LO: if (w_expire) w_nextState = ST_SCLK_HI;
         ST_SCLK_HI: if (w_expire) w_nextState = w_lastCol ? ST_LATCH : ST_FETCH;
         ST_LATCH:   if (w_expire) w_nextState = ST_DONE;
         ST_DONE:    w_nextState = start ? ST_FETCH : ST_IDLE;
         default:    w_nextState = ST_IDLE;
      endcase
      if (w_abort) begin
         w_nextState = ST_IDLE;
      end
      case (w_nextState)
         ST_WAIT:    w_timerVal = T_RD;
         ST_SCLK_LO: w_timerVal = T_DIV;
         ST_SCLK_HI: w_timerVal = T_DIV;
         ST_LATCH:   w_timerVal = T_LAT;
         default:    w_timerVal = TIMER_W'(1);
      endcase
      w_timerLoad = (w_nextState != r_state);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_rdAddress <= '0;
         r_rev       <= 1'b0;
         r_headSdat  <= '0;
         r_overrun   <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_abort) begin
            r_idx       <= '0;
            r_rdAddress <= '0;
            r_headSdat  <= '0;
         end else begin
            // Address walks one step per column; ADDR_W-bit arithmetic gives the wrap for free.
            if (w_accept) begin
               r_rev       <= rev;
               r_idx       <= '0;
               r_rdAddress <= base_addr + (rev ? LAST_IDX : '0);
            end else if (w_advance) begin
               r_idx       <= r_idx + 1'b1;
               r_rdAddress <= r_rev ? r_rdAddress - 1'b1 : r_rdAddress + 1'b1;
            end
            if ((r_state == ST_WAIT) && w_expire) begin
               r_headSdat <= bufBus.PrnData;
            end else if ((w_nextState == ST_LATCH) && (r_state != ST_LATCH)) begin
               r_headSdat <= '0;
            end
         end
         if (w_accept) begin
            r_overrun <= 1'b0;
         end else if (start && w_busy) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign bufBus.rden      = (r_state == ST_FETCH);
   assign bufBus.rdaddress = r_rdAddress;
   assign head_sdat        = r_headSdat;
   assign head_sclk        = (r_state == ST_SCLK_HI);
   assign head_latch       = (r_state == ST_LATCH);
   assign busy             = w_busy;
   assign done             = (r_state == ST_DONE);
   assign overrun          = r_overrun;

endmodule

// File: tb/tb_hn_line_reader.sv
// Bench for hn_line_reader: a default-size reader and a one-column corner instance,
// each checked every cycle against a line timeline model plus hand-computed pins.
module tb_hn_line_reader;

   localparam int AW = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst;
   logic [1:0]           start, rev, abort;
   logic [1:0][AW-1:0]   base;
   logic [1:0][3:0]      sdat;
   logic [1:0]           sclk, latch, busy, done, over;
   logic [1:0]           rdenV;
   logic [1:0][AW-1:0]   addrV;

   hn_line_reader_if #(.ADDR_W(AW)) busA ();
   hn_line_reader_if #(.ADDR_W(AW)) busB ();

   hn_line_reader #(.ADDR_W(AW), .LINE_LEN(100), .RD_LAT(2), .CLK_DIV(2), .LATCH_W(4)) dutA (
      .clk(clk), .rst(rst), .start(start[0]), .rev(rev[0]), .base_addr(base[0]), .abort(abort[0]),
      .bufBus(busA), .head_sdat(sdat[0]), .head_sclk(sclk[0]), .head_latch(latch[0]),
      .busy(busy[0]), .done(done[0]), .overrun(over[0])
   );

   hn_line_reader #(.ADDR_W(AW), .LINE_LEN(1), .RD_LAT(1), .CLK_DIV(1), .LATCH_W(4)) dutB (
      .clk(clk), .rst(rst), .start(start[1]), .rev(rev[1]), .base_addr(base[1]), .abort(abort[1]),
      .bufBus(busB), .head_sdat(sdat[1]), .head_sclk(sclk[1]), .head_latch(latch[1]),
      .busy(busy[1]), .done(done[1]), .overrun(over[1])
   );

   assign rdenV[0] = busA.rden;
   assign rdenV[1] = busB.rden;
   assign addrV[0] = busA.rdaddress;
   assign addrV[1] = busB.rdaddress;

   // Buffer bank: the word stored at address a is a[3:0], returned RD_LAT cycles after rden.
   logic [3:0] pipeA0 = '0, pipeA1 = '0, pipeB0 = '0;
   always @(posedge clk) begin
      pipeA0 <= busA.rden ? busA.rdaddress[3:0] : 4'h0;
      pipeA1 <= pipeA0;
      pipeB0 <= busB.rden ? busB.rdaddress[3:0] : 4'h0;
   end
   assign busA.PrnData = pipeA1;
   assign busB.PrnData = pipeB0;

   int LLp [2] = '{100, 1};
   int RLp [2] = '{2, 1};
   int CDp [2] = '{2, 1};
   int LWp [2] = '{4, 4};

   int nCompared = 0;
   int nMismatched = 0;
   int cyc = 0;

   bit mActive [2];
   bit mRev [2];
   bit mOver [2];
   int mT [2];
   int mBase [2];

   int nFetch [2], nRise [2], nLatch [2], firstFetchCyc [2], doneCyc [2];
   bit prevSclk [2];
   int fetchAddr [2][100];
   int riseData [2][100];

   typedef struct {
      bit rden, addrValid, sclk, latch, busy, done;
      int addr;
      bit [3:0] sdat;
   } expT;

   expT eCur;

   task automatic checkOutput(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL dut%0d %s: got %0d, expected %0d", d, name, act, exp);
      end
   endtask

   function automatic int colAddr(input int d, input int k);
      return (mBase[d] + (mRev[d] ? LLp[d] - 1 - k : k)) % 1024;
   endfunction

   // Outputs as a function of the cycle offset t from the first FETCH of the line.
   function automatic expT modelAt(input int d);
      expT e;
      int colLen, stream, t, k, p, a;
      e = '{default: 0};
      if (!mActive[d]) return e;
      t      = mT[d];
      colLen = 1 + RLp[d] + 2 * CDp[d];
      stream = LLp[d] * colLen;
      e.busy = (t < stream + LWp[d]);
      if (t < stream) begin
         k = t / colLen;
         p = t % colLen;
         e.rden      = (p == 0);
         e.addrValid = (p <= RLp[d]);
         e.addr      = colAddr(d, k);
         e.sclk      = (p >= 1 + RLp[d] + CDp[d]);
         if (p >= 1 + RLp[d]) begin
            a = colAddr(d, k);
            e.sdat = a[3:0];
         end else if (k > 0) begin
            a = colAddr(d, k - 1);
            e.sdat = a[3:0];
         end
      end else if (t < stream + LWp[d]) begin
         e.latch = 1'b1;
      end else begin
         e.done = 1'b1;
      end
      return e;
   endfunction

   // Line timeline model: advances once per clock from the sampled inputs.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         int total;
         total = LLp[d] * (1 + RLp[d] + 2 * CDp[d]) + LWp[d] + 1;
         if (rst) begin
            mActive[d] = 1'b0;
            mOver[d]   = 1'b0;
         end else if (start[d] && (!mActive[d] || mT[d] == total - 1)) begin
            mActive[d] = 1'b1;
            mT[d]      = 0;
            mBase[d]   = int'(base[d]);
            mRev[d]    = rev[d];
            mOver[d]   = 1'b0;
         end else if (mActive[d]) begin
            if (mT[d] == total - 1) begin
               mActive[d] = 1'b0;
            end else begin
               if (start[d]) mOver[d] = 1'b1;
               if (abort[d]) mActive[d] = 1'b0;
               else mT[d] = mT[d] + 1;
            end
         end
      end
   end

   // Per-cycle comparison plus line statistics for the directed pins.
   always @(posedge clk) begin
      #1;
      cyc++;
      for (int d = 0; d < 2; d++) begin
         eCur = modelAt(d);
         checkOutput("rden", d, rdenV[d], eCur.rden);
         checkOutput("head_sclk", d, sclk[d], eCur.sclk);
         checkOutput("head_latch", d, latch[d], eCur.latch);
         checkOutput("busy", d, busy[d], eCur.busy);
         checkOutput("done", d, done[d], eCur.done);
         checkOutput("head_sdat", d, sdat[d], eCur.sdat);
         checkOutput("overrun", d, over[d], mOver[d]);
         if (eCur.addrValid) checkOutput("rdaddress", d, addrV[d], eCur.addr);
         if (rdenV[d] === 1'b1) begin
            if (nFetch[d] == 0) firstFetchCyc[d] = cyc;
            if (nFetch[d] < 100) fetchAddr[d][nFetch[d]] = int'(addrV[d]);
            nFetch[d]++;
         end
         if (sclk[d] === 1'b1 && !prevSclk[d]) begin
            if (nRise[d] < 100) riseData[d][nRise[d]] = int'(sdat[d]);
            nRise[d]++;
         end
         prevSclk[d] = (sclk[d] === 1'b1);
         if (latch[d] === 1'b1) nLatch[d]++;
         if (done[d] === 1'b1) doneCyc[d] = cyc;
      end
   end

   // Called at a falling edge; holds start for one cycle.
   task automatic applyStimulus(input int d, input logic revV, input logic [AW-1:0] baseV, input bit newLine);
      if (newLine) begin
         nFetch[d] = 0;
         nRise[d]  = 0;
         nLatch[d] = 0;
      end
      start[d] = 1'b1;
      rev[d]   = revV;
      base[d]  = baseV;
      @(negedge clk);
      start[d] = 1'b0;
   endtask

   task automatic waitDone(input int d, input int budget);
      int n;
      n = 0;
      while (done[d] !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("doneWithinBudget", d, (n < budget), 1);
   endtask

   task automatic checkLine(input string tag, input int d, input int span, input int rises);
      checkOutput({tag, ".span"}, d, doneCyc[d] - firstFetchCyc[d] + 1, span);
      checkOutput({tag, ".rises"}, d, nRise[d], rises);
      checkOutput({tag, ".fetches"}, d, nFetch[d], rises);
      checkOutput({tag, ".latchCycles"}, d, nLatch[d], 4);
   endtask

   task automatic checkIdle(input string tag, input int d);
      checkOutput({tag, ".busy"}, d, busy[d], 0);
      checkOutput({tag, ".sclk"}, d, sclk[d], 0);
      checkOutput({tag, ".latch"}, d, latch[d], 0);
      checkOutput({tag, ".done"}, d, done[d], 0);
      checkOutput({tag, ".rden"}, d, rdenV[d], 0);
      checkOutput({tag, ".rdaddress"}, d, addrV[d], 0);
      checkOutput({tag, ".sdat"}, d, sdat[d], 0);
   endtask

   initial begin
      rst   = 1'b1;
      start = '0;
      rev   = '0;
      abort = '0;
      base  = '0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checkIdle("reset", d);
         checkOutput("reset.overrun", d, over[d], 0);
      end
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] ascending line");
      applyStimulus(0, 1'b0, 10'd0, 1'b1);
      checkOutput("asc.busyRise", 0, busy[0], 1);
      waitDone(0, 800);
      checkLine("asc", 0, 705, 100);
      checkOutput("asc.firstAddr", 0, fetchAddr[0][0], 0);
      checkOutput("asc.lastAddr", 0, fetchAddr[0][99], 99);
      checkOutput("asc.rise0", 0, riseData[0][0], 0);
      checkOutput("asc.rise1", 0, riseData[0][1], 1);
      checkOutput("asc.rise15", 0, riseData[0][15], 15);
      checkOutput("asc.rise16", 0, riseData[0][16], 0);
      checkOutput("asc.rise99", 0, riseData[0][99], 3);

      $display("[TB] descending with wrap, started in the done cycle");
      applyStimulus(0, 1'b1, 10'd1000, 1'b1);
      checkOutput("desc.busyRise", 0, busy[0], 1);
      waitDone(0, 800);
      checkLine("desc", 0, 705, 100);
      checkOutput("desc.firstAddr", 0, fetchAddr[0][0], 75);
      checkOutput("desc.addrAt75", 0, fetchAddr[0][75], 0);
      checkOutput("desc.addrAt76", 0, fetchAddr[0][76], 1023);
      checkOutput("desc.lastAddr", 0, fetchAddr[0][99], 1000);
      checkOutput("desc.rise0", 0, riseData[0][0], 11);
      checkOutput("desc.rise75", 0, riseData[0][75], 0);
      checkOutput("desc.rise76", 0, riseData[0][76], 15);
      checkOutput("desc.rise99", 0, riseData[0][99], 8);
      repeat (3) @(negedge clk);

      $display("[TB] overrun");
      applyStimulus(0, 1'b0, 10'd200, 1'b1);
      repeat (72) @(negedge clk);
      applyStimulus(0, 1'b1, 10'd5, 1'b0);
      checkOutput("ovr.flagSet", 0, over[0], 1);
      waitDone(0, 800);
      checkLine("ovr", 0, 705, 100);
      checkOutput("ovr.flagHeld", 0, over[0], 1);
      checkOutput("ovr.firstAddr", 0, fetchAddr[0][0], 200);
      checkOutput("ovr.lastAddr", 0, fetchAddr[0][99], 299);
      applyStimulus(0, 1'b0, 10'd0, 1'b1);
      checkOutput("ovr.flagCleared", 0, over[0], 0);

      $display("[TB] abort during column 50 high phase");
      repeat (355) @(negedge clk);
      checkOutput("abort.sclkHigh", 0, sclk[0], 1);
      abort[0] = 1'b1;
      @(negedge clk);
      abort[0] = 1'b0;
      checkIdle("abort", 0);
      repeat (20) @(negedge clk);
      checkOutput("abort.noLatch", 0, nLatch[0], 0);
      applyStimulus(0, 1'b0, 10'd512, 1'b1);
      waitDone(0, 800);
      checkLine("afterAbort", 0, 705, 100);
      checkOutput("afterAbort.firstAddr", 0, fetchAddr[0][0], 512);
      repeat (3) @(negedge clk);

      $display("[TB] reset mid-line");
      applyStimulus(0, 1'b0, 10'd0, 1'b1);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      checkOutput("rstMid.overrunBefore", 0, over[0], 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkIdle("rstMid", 0);
      checkOutput("rstMid.overrun", 0, over[0], 0);
      repeat (3) @(negedge clk);

      $display("[TB] one-column corner instance");
      applyStimulus(1, 1'b0, 10'd37, 1'b1);
      waitDone(1, 50);
      checkLine("corner", 1, 9, 1);
      checkOutput("corner.addr", 1, fetchAddr[1][0], 37);
      checkOutput("corner.data", 1, riseData[1][0], 5);
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/hn_line_reader.md
# hn_line_reader

Read-side sequencer for the four print-head line buffers. On a start command it sweeps the shared read address across one line, pulls the 4-bit column word (one bit per head) from the buffers, and shifts it out serially to all four heads in parallel. When the line is complete it issues a head latch pulse. It sits between the line-buffer bank (`rden`/`rdaddress` in, `PrnData` back) and the head driver pins.

## Interface
Parameters:
- `ADDR_W`, 10: buffer read address width.
- `LINE_LEN`, 100: columns (bits per head) per line; legal range 1..2^ADDR_W.
- `RD_LAT`, 2: cycles from `rden` to valid `PrnData`; legal range ≥1.
- `CLK_DIV`, 2: cycles per `head_sclk` half-period; legal range ≥1.
- `LATCH_W`, 4: `head_latch` pulse width in cycles; legal range ≥1.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: reset; synchronous, active-high.
- `start`  in  1: one-cycle line request.
- `rev`  in  1: scan direction, sampled with `start`; 0 = ascending, 1 = descending.
- `base_addr`  in  ADDR_W: first buffer address of the line, sampled with `start`.
- `abort`  in  1: cancels the current line.
- `rden`  out  1: buffer read enable.
- `rdaddress`  out  ADDR_W: buffer read address.
- `PrnData`  in  4: buffer read data; bit n belongs to head n+1.
- `head_sdat`  out  4: serial data, one bit per head.
- `head_sclk`  out  1: shift clock common to all heads.
- `head_latch`  out  1: line latch strobe.
- `busy`  out  1: line in progress.
- `done`  out  1: one-cycle completion pulse.
- `overrun`  out  1: sticky flag; a start arrived while busy.

## Operation
- States: IDLE, FETCH, WAIT, SCLK_LO, SCLK_HI, LATCH, DONE.
- **IDLE**
  - On `start`, capture `base_addr` and `rev`, clear column index `idx`, set `busy`, go to FETCH.
- **FETCH**, 1 cycle
  - `rden`=1.
  - `rdaddress` = `base_addr + idx` when `rev`=0, or `base_addr + (LINE_LEN-1-idx)` when `rev`=1.
  - The sum is truncated to ADDR_W bits, so it wraps modulo 2^ADDR_W.
- **WAIT**, RD_LAT cycles
  - `rden`=0; `rdaddress` holds.
  - On the last WAIT cycle, register `PrnData` into `head_sdat`.
- **SCLK_LO**, CLK_DIV cycles: `head_sclk`=0; `head_sdat` is stable.
- **SCLK_HI**, CLK_DIV cycles
  - `head_sclk`=1; heads sample on the rising edge.
  - At exit, if `idx == LINE_LEN-1` go to LATCH; otherwise `idx++` and go to FETCH.
- **LATCH**, LATCH_W cycles
  - `head_latch`=1, `head_sclk`=0, `head_sdat`=0.
- **DONE**, 1 cycle: `done`=1, `busy`=0, then go to IDLE.
- `start` outside IDLE is ignored and sets `overrun`. `overrun` is cleared only by `rst` or by a `start` accepted in IDLE.
- `abort` is active in any non-IDLE state. On the next edge the block goes to IDLE, all outputs except `overrun` return to reset values, and no `done` is issued.
- `start` and `abort` together in IDLE: `abort` is ignored and `start` is accepted.

## Timing
- Reset values: `rden`=0, `rdaddress`=0, `head_sdat`=0, `head_sclk`=0, `head_latch`=0, `busy`=0, `done`=0, `overrun`=0.
- `rst` has priority over every other input, including mid-line.
- `busy` rises the cycle after `start` is accepted.
- Cycles per column: 1 + RD_LAT + 2·CLK_DIV; 7 at defaults.
- Line duration, from the first FETCH to the `done` pulse inclusive: LINE_LEN·(1+RD_LAT+2·CLK_DIV) + LATCH_W + 1; 705 at defaults.
- `head_sdat` changes only on entry to SCLK_LO, so it is stable for the full `head_sclk` period. Setup and hold to the rising edge are each CLK_DIV cycles.
- `start` is accepted in the cycle `done` is high. Back-to-back lines therefore leave one idle cycle.

## Structure
- Shared package `hn_pkg`: state enum, default values for LINE_LEN, RD_LAT and CLK_DIV, and the head count constant (4).
- One sub-module, `hn_sclk_timer`: a down-counter loaded per state with RD_LAT, CLK_DIV or LATCH_W, with an `expire` output.
- The FSM, address generator and data register stay in `hn_line_reader`.

## Test plan
- **Ascending line:** `base_addr`=0, `rev`=0, buffer word at address a = a[3:0] → `rdaddress` goes 0..99. `head_sdat` at the k-th sclk rise = k[3:0]. Exactly 100 rises, one `head_latch` of 4 cycles, `done` 705 cycles after the first FETCH.
- **Descending with wrap:** `base_addr`=1000, `rev`=1 → the first address is 1099 mod 1024 = 75. Addresses descend through 0 to 1023 and the last is 1000. Data order follows the addresses.
- **Overrun:** `start` pulsed at column 10 → line completes unchanged and `overrun`=1. The next accepted `start` clears it.
- **Abort:** `abort` at column 50 during SCLK_HI → on the next edge the block is in IDLE with `busy`=0 and `head_sclk`=0. No `head_latch` and no `done`; the following line runs normally.
- **Reset mid-line:** `rst` during WAIT → all outputs at reset values on the next edge, `overrun` included.
- **Corner parameters:** LINE_LEN=1, RD_LAT=1, CLK_DIV=1 → a single sclk pulse carrying PrnData of `base_addr`, then the latch. `done` arrives 4+LATCH_W+1 cycles after FETCH.
